pipe_ctrl: RTL

Central pipeline sequencer for the 5-stage core: s0 fetch, s1 decode, s2 execute, s3 memory, s4 writeback.
- Drives the per-stage en/flush inputs of every stage's d_register pipeline registers; these are currently left unconnected.
- Handles three hazards: load-use stalls, data-memory wait stalls, and branch/jump redirects resolved in writeback.
- Also provides a redirect PC to fetch, a memory-timeout error flag and a stall counter.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl_ld_use_detect.sv | 22 ++
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Stage bit i of every en/flush vector maps to stage si.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_REDIRECT
  } state_t;

  localparam int S_FETCH  = 0;
  localparam int S_DECODE = 1;
  localparam int S_EXEC   = 2;
  localparam int S_MEM    = 3;
  localparam int S_WB     = 4;

  localparam logic [4:0] EN_ALL     = 5'b11111;
  localparam logic [4:0] EN_NONE    = 5'b00000;
  localparam logic [4:0] FLUSH_NONE = 5'b00000;
  localparam logic [4:0] FLUSH_ALL  = 5'b11111;

  // Only writeback advances while dmem is busy.
  localparam logic [4:0] EN_MEM_WAIT    = 5'b1 << S_WB;
  localparam logic [4:0] FLUSH_MEM_WAIT = 5'b1 << S_WB;

  localparam logic [4:0] EN_LD_USE    = 5'b11100;
  localparam logic [4:0] FLUSH_LD_USE = 5'b1 << S_EXEC;

  localparam logic [4:0] FLUSH_REDIR  = FLUSH_ALL & ~(5'b1 << S_WB);
  localparam logic [4:0] FLUSH_BUBBLE = 5'b1 << S_FETCH;

endpackage

// File: rtl/pipe_ctrl_ld_use_detect.sv
// Load-use hazard compare between decode sources and execute rd.
// x0 is hardwired zero, so it never creates a dependency.
module ld_use_detect (
  input  logic [4:0] id_rs1_ind,
  input  logic [4:0] id_rs2_ind,
  input  logic [1:0] id_rs_use,
  input  logic [4:0] ex_rd_ind,
  input  logic       ex_is_load,
  output logic       hit
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs_use[0] && (id_rs1_ind == ex_rd_ind);
  assign rs2_hit = id_rs_use[1] && (id_rs2_ind == ex_rd_ind);

  assign hit = ex_is_load
            && (ex_rd_ind != 5'd0)
            && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage enable/flush, redirect PC,
// dmem timeout flag and stall counter for the 5-stage core.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIR_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp_take,
  input  logic [31:0] jmp_addr,
  input  logic [4:0]  id_rs1_ind,
  input  logic [4:0]  id_rs2_ind,
  input  logic [1:0]  id_rs_use,
  input  logic [4:0]  ex_rd_ind,
  input  logic        ex_is_load,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic [4:0]  stage_en,
  output logic [4:0]  stage_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_addr,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] REDIR_LOAD = 4'(REDIR_BUBBLES);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  redir_cnt_q, redir_cnt_d;
  logic        err_set;
  logic        ld_hit;

  ld_use_detect u_ld_use (
    .id_rs1_ind (id_rs1_ind),
    .id_rs2_ind (id_rs2_ind),
    .id_rs_use  (id_rs_use),
    .ex_rd_ind  (ex_rd_ind),
    .ex_is_load (ex_is_load),
    .hit        (ld_hit)
  );

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    redir_cnt_d      = redir_cnt_q;
    stage_en         = EN_ALL;
    stage_flush      = FLUSH_NONE;
    pc_redirect      = 1'b0;
    pc_redirect_addr = 32'd0;
    if (rst) begin
      stage_en    = EN_NONE;
      stage_flush = FLUSH_ALL;
      state_d     = ST_RUN;
      wait_cnt_d  = 16'd0;
      redir_cnt_d = 4'd0;
    end else if (jmp_take) begin
      // Flushing s3 also kills any pending dmem wait.
      pc_redirect      = 1'b1;
      pc_redirect_addr = jmp_addr;
      stage_flush      = FLUSH_REDIR;
      wait_cnt_d       = 16'd0;
      redir_cnt_d      = REDIR_LOAD;
      state_d          = (REDIR_LOAD == 4'd0) ? ST_RUN
                                              : ST_REDIRECT;
    end else begin
      unique case (state_q)
        ST_REDIRECT: begin
          stage_flush = FLUSH_BUBBLE;
          redir_cnt_d = redir_cnt_q - 4'd1;
          if (redir_cnt_q == 4'd1) state_d = ST_RUN;
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state_d    = ST_RUN;
            wait_cnt_d = 16'd0;
          end else begin
            stage_en    = EN_MEM_WAIT;
            stage_flush = FLUSH_MEM_WAIT;
            if (wait_cnt_q != 16'hFFFF)
              wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end
        default: begin
          if (mem_req && !dmem_ready) begin
            stage_en    = EN_MEM_WAIT;
            stage_flush = FLUSH_MEM_WAIT;
            state_d     = ST_MEM_WAIT;
            wait_cnt_d  = 16'd1;
          end else if (ld_hit) begin
            stage_en    = EN_LD_USE;
            stage_flush = FLUSH_LD_USE;
          end
        end
      endcase
    end
  end

  assign err_set = (state_d == ST_MEM_WAIT)
                && (32'(wait_cnt_d) >= MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      wait_cnt_q      <= 16'd0;
      redir_cnt_q     <= 4'd0;
      mem_timeout_err <= 1'b0;
      stall_cnt       <= 32'd0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      redir_cnt_q     <= redir_cnt_d;
      mem_timeout_err <= mem_timeout_err | err_set;
      if (stage_en != EN_ALL && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
